ysyx_25040111_icache_sa: RTL and testbench
==========================================

YSYX_25040111_ICACHE_SA -- requirements
Module: ysyx_25040111_icache_sa

Interface
REQ-001 SHALL have parameter SET_Ls, default 3, meaning log2 of set count (8 sets).
REQ-002 SHALL have parameter BLOCK_Ls, default 4, meaning log2 of block bytes (16 B = 4 words); legal range 2..6.
REQ-003 SHALL have parameter WAYS fixed at 2, meaning associativity; other values are illegal.
REQ-004 SHALL have port clock  in  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port addr  in  32  fetch address, word aligned, held stable while valid is high and ready is low.
REQ-007 SHALL have port valid  in  1  fetch request; requester holds it high until ready.
REQ-008 SHALL have port ready  out  1  single-cycle response strobe.
REQ-009 SHALL have port data  out  32  fetched word, meaningful when ready is high.
REQ-010 SHALL have port flush  in  1  single-cycle invalidate-all request (fence.i).
REQ-011 SHALL have port rstart  out  1  single-cycle burst-read start pulse.
REQ-012 SHALL have port raddr  out  32  block-aligned burst base address.
REQ-013 SHALL have port rlen  out  8  burst beats minus one, constant 2**(BLOCK_Ls-2)-1.
REQ-014 SHALL have port rok  in  1  one returned beat per high cycle, beat k at raddr+4k.
REQ-015 SHALL have port rdata  in  32  beat data, valid with rok.
REQ-016 SHALL have ports hit_cnt and miss_cnt  out  32 each  wrapping performance counters.

Function
REQ-017 SHALL decode tag=addr[31:SET_Ls+BLOCK_Ls], set=addr[SET_Ls+BLOCK_Ls-1:BLOCK_Ls], word=addr[BLOCK_Ls-1:2].
REQ-018 SHALL store, per set and way, a valid bit, tag and block; per set, one LRU bit naming the way to evict next.
REQ-019 SHALL implement FSM states IDLE, REFILL, RESP; reset state IDLE.
REQ-020 SHALL, in IDLE with valid high, flush low and a tag match in a valid way, assert ready with the selected word the next cycle, set LRU to the other way, increment hit_cnt, and remain in IDLE.
REQ-021 SHALL, in IDLE with valid high, flush low and no match, pulse rstart for exactly one cycle on the next cycle, with raddr={addr[31:BLOCK_Ls],0}, latch addr, increment miss_cnt, and enter REFILL.
REQ-022 SHALL choose the victim way as: way0 if invalid; else way1 if invalid; else the way named by LRU; the choice is fixed at miss time.
REQ-023 SHALL, in REFILL, write each rok beat into word position beat-count of the victim block, and capture the beat whose index equals the latched word offset.
REQ-024 SHALL, on the final beat (count==rlen), write the victim tag, set its valid bit, set LRU to the other way, and enter RESP.
REQ-025 SHALL, in RESP, assert ready for one cycle with the captured word and return to IDLE; miss latency is one cycle after the final rok.
REQ-026 SHALL ignore rok in IDLE and RESP and ignore valid outside IDLE.
REQ-027 SHALL, on flush in IDLE, clear all valid bits the next cycle, leave LRU bits unchanged, and not respond to a coincident valid that cycle (flush has priority; the request is served after the flush).
REQ-028 SHALL, on flush in REFILL or RESP, latch a pending flag, complete the current refill and response normally, and apply the invalidate on the first IDLE cycle, again blocking responses for that cycle.
REQ-029 SHALL hold ready low except as required by REQ-020 and REQ-025; data holds its last value otherwise.
REQ-030 SHALL let hit_cnt and miss_cnt wrap from 0xFFFF_FFFF to 0.

Reset
REQ-031 SHALL, on reset, clear all valid bits, LRU bits, beat counter and pending-flush flag, enter IDLE, and drive ready=0, data=0, rstart=0, raddr=0, hit_cnt=0 and miss_cnt=0; block and tag storage are not reset.
REQ-032 SHALL, when reset is asserted mid-refill, abandon the burst, ignore later beats, and miss on the next access.

Verification (defaults)
REQ-033 SHALL cover: a cold fetch at 0x8000_0014 -> rstart pulse, raddr=0x8000_0010, rlen=3; beats 0x11,0x22,0x33,0x44 -> ready with data=0x22 one cycle after the 4th rok; a refetch -> ready next cycle with 0x22, no rstart, hit_cnt=1.
REQ-034 SHALL cover: a fill of 0x8000_0010 then 0x8000_0090 (set 1), a hit on 0x8000_0010, then a miss on 0x8000_0110 -> the way holding 0x90 is evicted; 0x8000_0010 then hits and 0x8000_0090 misses.
REQ-035 SHALL cover: flush after two filled lines -> both addresses miss afterwards; a coincident valid is answered only after the refill.
REQ-036 SHALL cover: flush pulsed during beat 2 of a refill -> the response completes with the correct word, the same address then misses.
REQ-037 SHALL cover: reset at beat 2 of a refill -> all outputs 0 the next cycle, stray rok ignored, the same address then misses with miss_cnt=1.

Source files
------------

// File: rtl/ysyx_25040111_icache_sa.sv
// Two-way set-associative instruction cache with per-set LRU, burst refill
// and a deferred fence.i flush. Storage arrays are not reset; only valid/LRU state is.
module ysyx_25040111_icache_sa #(
    parameter int SET_Ls   = 3,
    parameter int BLOCK_Ls = 4,
    parameter int WAYS     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        valid,
    output logic        ready,
    output logic [31:0] data,
    input  logic        flush,
    output logic        rstart,
    output logic [31:0] raddr,
    output logic [7:0]  rlen,
    input  logic        rok,
    input  logic [31:0] rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [1:0]  dbg_state
);

    localparam int SETS  = 1 << SET_Ls;
    localparam int WORDS = 1 << (BLOCK_Ls - 2);
    localparam int CNT_W = (BLOCK_Ls > 2) ? (BLOCK_Ls - 2) : 1;
    localparam int TAG_W = 32 - SET_Ls - BLOCK_Ls;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    // Only WAYS == 2 is supported: victim/LRU logic is a single bit per set.
    logic [31:0]      blocks [SETS][WAYS][WORDS];
    logic [TAG_W-1:0] tags   [SETS][WAYS];
    logic [WAYS-1:0]  valids [SETS];
    logic [SETS-1:0]  lru;

    logic [SET_Ls-1:0] req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [CNT_W-1:0]  req_word;
    logic              victim;
    logic [CNT_W-1:0]  beat_cnt;
    logic [31:0]       captured;
    logic              flush_pending;

    logic [SET_Ls-1:0] cur_set;
    logic [TAG_W-1:0]  cur_tag;
    logic [CNT_W-1:0]  cur_word;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic [31:0]       hit_word;
    logic              victim_sel;

    assign cur_set  = SET_Ls'(addr >> BLOCK_Ls);
    assign cur_tag  = TAG_W'(addr >> (SET_Ls + BLOCK_Ls));
    assign cur_word = CNT_W'((addr >> 2) & 32'(WORDS - 1));

    assign rlen      = 8'(WORDS - 1);
    assign dbg_state = state;

    always_comb begin
        hit0     = valids[cur_set][0] && (tags[cur_set][0] == cur_tag);
        hit1     = valids[cur_set][1] && (tags[cur_set][1] == cur_tag);
        hit      = hit0 || hit1;
        hit_way  = hit1;
        hit_word = blocks[cur_set][hit_way][cur_word];
        if (!valids[cur_set][0]) begin
            victim_sel = 1'b0;
        end else if (!valids[cur_set][1]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = lru[cur_set];
        end
    end

    // Handshake: valid is held until ready; the cycle in which ready is high
    // completes the request, so a still-high valid in that cycle is not a new fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ready         <= 1'b0;
            data          <= 32'd0;
            rstart        <= 1'b0;
            raddr         <= 32'd0;
            hit_cnt       <= 32'd0;
            miss_cnt      <= 32'd0;
            lru           <= '0;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
            req_set       <= '0;
            req_tag       <= '0;
            req_word      <= '0;
            victim        <= 1'b0;
            captured      <= 32'd0;
            for (int s = 0; s < SETS; s++) begin
                valids[s] <= '0;
            end
        end else begin
            ready  <= 1'b0;
            rstart <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush || flush_pending) begin
                        for (int s = 0; s < SETS; s++) begin
                            valids[s] <= '0;
                        end
                        flush_pending <= 1'b0;
                    end else if (valid && !ready) begin
                        if (hit) begin
                            ready        <= 1'b1;
                            data         <= hit_word;
                            lru[cur_set] <= ~hit_way;
                            hit_cnt      <= hit_cnt + 32'd1;
                        end else begin
                            rstart   <= 1'b1;
                            raddr    <= addr & ~((32'd1 << BLOCK_Ls) - 32'd1);
                            req_set  <= cur_set;
                            req_tag  <= cur_tag;
                            req_word <= cur_word;
                            victim   <= victim_sel;
                            beat_cnt <= '0;
                            miss_cnt <= miss_cnt + 32'd1;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (rok) begin
                        if (beat_cnt == req_word) begin
                            captured <= rdata;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            valids[req_set][victim] <= 1'b1;
                            lru[req_set]            <= ~victim;
                            ready                   <= 1'b1;
                            data                    <= (beat_cnt == req_word) ? rdata : captured;
                            beat_cnt                <= '0;
                            state                   <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Block and tag storage: written only by accepted refill beats.
    always_ff @(posedge clock) begin
        if (!reset && (state == REFILL) && rok) begin
            blocks[req_set][victim][beat_cnt] <= rdata;
            if (beat_cnt == LAST_BEAT) begin
                tags[req_set][victim] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_icache_sa.sv
// Directed bench for the two-way icache: a per-set recency-list model predicts
// hits, misses, burst addresses and returned words; a negedge process compares.
module tb_ysyx_25040111_icache_sa;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr  = 32'd0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] data;
    logic        flush = 1'b0;
    logic        rstart;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic        rok   = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [1:0]  dbg_state;

    always #5 clock = ~clock;

    ysyx_25040111_icache_sa dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .valid     (valid),
        .ready     (ready),
        .data      (data),
        .flush     (flush),
        .rstart    (rstart),
        .raddr     (raddr),
        .rlen      (rlen),
        .rok       (rok),
        .rdata     (rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .dbg_state (dbg_state)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    logic        check_en = 1'b0;
    logic        exp_ready  = 1'b0;
    logic        exp_rstart = 1'b0;
    logic [31:0] exp_data   = 32'd0;
    logic [31:0] exp_raddr  = 32'd0;
    logic [31:0] m_hits     = 32'd0;
    logic [31:0] m_misses   = 32'd0;

    // Per set: resident tags ordered least- to most-recently used.
    int          m_cnt [8];
    logic [24:0] m_tag [8][2];
    bit          m_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("ready", {31'd0, ready}, {31'd0, exp_ready});
            check("rstart", {31'd0, rstart}, {31'd0, exp_rstart});
            check("data", data, exp_data);
            check("raddr", raddr, exp_raddr);
            check("rlen", {24'd0, rlen}, 32'd3);
            check("hit_cnt", hit_cnt, m_hits);
            check("miss_cnt", miss_cnt, m_misses);
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000001) begin
            case (a[3:2])
                2'd0:    return 32'h11;
                2'd1:    return 32'h22;
                2'd2:    return 32'h33;
                default: return 32'h44;
            endcase
        end
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic bit m_lookup(input logic [31:0] a);
        int s = int'(a[6:4]);
        for (int i = 0; i < m_cnt[s]; i++) begin
            if (m_tag[s][i] == a[31:7]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_touch(input logic [31:0] a);
        int s = int'(a[6:4]);
        if (m_cnt[s] == 2 && m_tag[s][0] == a[31:7]) begin
            m_tag[s][0] = m_tag[s][1];
            m_tag[s][1] = a[31:7];
        end
    endtask

    task automatic m_fill(input logic [31:0] a);
        int s = int'(a[6:4]);
        if (m_cnt[s] == 2) begin
            m_tag[s][0] = m_tag[s][1];
            m_tag[s][1] = a[31:7];
        end else begin
            m_tag[s][m_cnt[s]] = a[31:7];
            m_cnt[s]++;
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < 8; s++) m_cnt[s] = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        exp_ready  = 1'b0;
        exp_rstart = 1'b0;
    endtask

    // One fetch: optional coincident flush, beat gaps, flush or reset at a beat index.
    task automatic fetch(input logic [31:0] a, input bit with_flush, input int gap,
                         input int flush_beat, input int reset_beat);
        logic [31:0] base;
        base  = {a[31:4], 4'h0};
        addr  = a;
        valid = 1'b1;
        if (with_flush) flush = 1'b1;
        if (with_flush || m_pend) begin
            tick();
            flush  = 1'b0;
            m_pend = 1'b0;
            m_clear();
        end
        if (m_lookup(a)) begin
            tick();
            exp_ready = 1'b1;
            exp_data  = mem_word(a);
            m_hits++;
            m_touch(a);
        end else begin
            tick();
            exp_rstart = 1'b1;
            exp_raddr  = base;
            m_misses++;
            for (int k = 0; k < 4; k++) begin
                for (int g = 0; g < gap; g++) tick();
                rok   = 1'b1;
                rdata = mem_word(base + 32'(4 * k));
                if (k == flush_beat) begin
                    flush  = 1'b1;
                    m_pend = 1'b1;
                end
                if (k == reset_beat) reset = 1'b1;
                tick();
                rok   = 1'b0;
                flush = 1'b0;
                rdata = 32'hDEAD_BEEF;
                if (k == reset_beat) begin
                    reset     = 1'b0;
                    valid     = 1'b0;
                    exp_data  = 32'd0;
                    exp_raddr = 32'd0;
                    m_hits    = 32'd0;
                    m_misses  = 32'd0;
                    m_pend    = 1'b0;
                    m_clear();
                    return;
                end
            end
            exp_ready = 1'b1;
            exp_data  = mem_word(a);
            m_fill(a);
        end
        rok   = 1'b1;
        rdata = 32'hBAD0_0000;
        tick();
        rok   = 1'b0;
        valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_clear();
    endtask

    initial begin
        m_clear();
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b0;

        // Cold miss then hits within the same block.
        fetch(32'h8000_0014, 1'b0, 0, -1, -1);
        check("lit_cold_data", data, 32'h22);
        check("lit_cold_raddr", raddr, 32'h8000_0010);
        check("lit_rlen", {24'd0, rlen}, 32'd3);
        fetch(32'h8000_0014, 1'b0, 0, -1, -1);
        check("lit_refetch_data", data, 32'h22);
        check("lit_refetch_hits", hit_cnt, 32'd1);
        check("lit_refetch_misses", miss_cnt, 32'd1);
        fetch(32'h8000_001C, 1'b0, 0, -1, -1);
        check("lit_word3", data, 32'h44);

        // LRU eviction within set 1.
        fetch(32'h8000_0090, 1'b0, 1, -1, -1);
        fetch(32'h8000_0010, 1'b0, 0, -1, -1);
        check("lit_hit_0x10", data, 32'h11);
        fetch(32'h8000_0110, 1'b0, 0, -1, -1);
        fetch(32'h8000_0010, 1'b0, 0, -1, -1);
        fetch(32'h8000_0090, 1'b0, 0, -1, -1);
        check("lit_evict_data", data, 32'h5EAD_0090);
        check("lit_evict_hits", hit_cnt, 32'd4);
        check("lit_evict_misses", miss_cnt, 32'd4);

        // Flush with a coincident request, then a plain flush with stray beats.
        fetch(32'h8000_0010, 1'b1, 0, -1, -1);
        fetch(32'h8000_0090, 1'b0, 0, -1, -1);
        do_flush();
        rok   = 1'b1;
        rdata = 32'h0BAD_0BAD;
        tick();
        rok   = 1'b0;
        fetch(32'h8000_0094, 1'b0, 2, -1, -1);
        check("lit_flush_misses", miss_cnt, 32'd7);

        // Flush during beat 2: response intact, invalidate applied afterwards.
        fetch(32'h8000_0028, 1'b0, 0, 2, -1);
        check("lit_pend_data", data, 32'h5EAD_0028);
        fetch(32'h8000_0028, 1'b0, 0, -1, -1);
        fetch(32'h8000_0028, 1'b0, 0, -1, -1);
        check("lit_pend_hits", hit_cnt, 32'd5);
        check("lit_pend_misses", miss_cnt, 32'd9);

        // Reset at beat 2 abandons the burst.
        fetch(32'h8000_0034, 1'b0, 0, -1, 2);
        check("lit_rst_data", data, 32'd0);
        check("lit_rst_raddr", raddr, 32'd0);
        check("lit_rst_miss", miss_cnt, 32'd0);
        rok   = 1'b1;
        rdata = 32'h7777_7777;
        tick();
        tick();
        rok   = 1'b0;
        fetch(32'h8000_0034, 1'b0, 0, -1, -1);
        check("lit_rst_refetch_miss", miss_cnt, 32'd1);
        check("lit_rst_refetch_data", data, 32'h5EAD_0034);

        tick();
        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
